// File: rtl/axi_sts_scan_pkg.sv
// Shared state encoding and sizing helpers for the AXI status alert scanner.
package axi_sts_scan_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_EMIT,
    ST_DONE,
    ST_HOLDOFF
  } scan_state_t;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  // Number of bits needed to represent value (0 for value 0).
  function automatic int clogb2(input int value);
    int v;
    int bits;
    v    = value;
    bits = 0;
    while (v > 0) begin
      v    = v >> 1;
      bits = bits + 1;
    end
    return bits;
  endfunction

  function automatic int idx_width(input int words);
    int w;
    w = clogb2(words - 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/axi_sts_alert_scanner.sv
// AXI4-Lite read master that rescans the status words on alert or request and
// streams out only the words that differ from its local shadow copy.
module axi_sts_alert_scanner
  import axi_sts_scan_pkg::*;
#(
  parameter int          STS_WORDS      = 32,
  parameter int          AXI_DATA_WIDTH = 32,
  parameter int          AXI_ADDR_WIDTH = 16,
  parameter int unsigned BASE_ADDR      = 0,
  parameter int          HOLDOFF_CYCLES = 4
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic                      enable,
  input  logic                      alert,
  input  logic                      scan_req,
  output logic                      busy,
  output logic                      scan_done,
  output logic [15:0]               changed_count,
  output logic [15:0]               err_count,
  output logic [AXI_ADDR_WIDTH-1:0] m_axi_araddr,
  output logic                      m_axi_arvalid,
  input  logic                      m_axi_arready,
  input  logic [AXI_DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]                m_axi_rresp,
  input  logic                      m_axi_rvalid,
  output logic                      m_axi_rready,
  output logic [AXI_DATA_WIDTH-1:0] m_axis_tdata,
  output logic [15:0]               m_axis_tuser,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready
);

  localparam int               IDX_W     = idx_width(STS_WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(STS_WORDS - 1);
  localparam logic [15:0]      HOLD_LOAD = 16'(HOLDOFF_CYCLES - 1);

  scan_state_t               state;
  logic [IDX_W-1:0]          idx;
  logic [15:0]               chg_cnt;
  logic [15:0]               chg_cnt_next;
  logic [15:0]               hold_cnt;
  logic                      req_pend;
  logic [AXI_DATA_WIDTH-1:0] shadow [STS_WORDS];

  logic rd_fire;
  logic rd_ok;
  logic word_changed;
  logic emit_fire;
  logic advance;
  logic last_word;

  function automatic logic [AXI_ADDR_WIDTH-1:0] word_addr(input logic [IDX_W-1:0] i);
    return AXI_ADDR_WIDTH'(BASE_ADDR) + (AXI_ADDR_WIDTH'(i) << 2);
  endfunction

  // A word is finished either by a read that produced no event or by the event handshake.
  always_comb begin
    rd_fire      = (state == ST_DATA) && m_axi_rvalid;
    rd_ok        = (m_axi_rresp == RESP_OKAY);
    word_changed = rd_fire && rd_ok && (m_axi_rdata != shadow[idx]);
    emit_fire    = (state == ST_EMIT) && m_axis_tready;
    advance      = (rd_fire && !word_changed) || emit_fire;
    last_word    = (idx == LAST_IDX);
    chg_cnt_next = emit_fire ? chg_cnt + 16'd1 : chg_cnt;
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state         <= ST_IDLE;
      idx           <= '0;
      chg_cnt       <= '0;
      hold_cnt      <= '0;
      req_pend      <= 1'b0;
      busy          <= 1'b0;
      scan_done     <= 1'b0;
      changed_count <= '0;
      err_count     <= '0;
      m_axi_araddr  <= word_addr('0);
      m_axi_arvalid <= 1'b0;
      m_axi_rready  <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tuser  <= '0;
      m_axis_tvalid <= 1'b0;
    end else begin
      scan_done <= 1'b0;
      if (scan_req) req_pend <= 1'b1;

      case (state)
        ST_IDLE: begin
          if ((enable && alert) || req_pend) begin
            state         <= ST_ADDR;
            idx           <= '0;
            chg_cnt       <= '0;
            busy          <= 1'b1;
            m_axi_araddr  <= word_addr('0);
            m_axi_arvalid <= 1'b1;
            if (!scan_req) req_pend <= 1'b0;
          end
        end
        ST_ADDR: begin
          if (m_axi_arready) begin
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b1;
            state         <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (m_axi_rvalid) begin
            m_axi_rready <= 1'b0;
            if (!rd_ok && err_count != 16'hFFFF) err_count <= err_count + 16'd1;
            if (word_changed) begin
              m_axis_tdata  <= m_axi_rdata;
              m_axis_tuser  <= 16'(idx);
              m_axis_tvalid <= 1'b1;
              state         <= ST_EMIT;
            end
          end
        end
        ST_EMIT: begin
          if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
            chg_cnt       <= chg_cnt_next;
          end
        end
        ST_DONE: begin
          hold_cnt <= HOLD_LOAD;
          state    <= ST_HOLDOFF;
        end
        ST_HOLDOFF: begin
          if (hold_cnt == 16'd0) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt - 16'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase

      // Shared word-advance path overrides the per-state next state above.
      if (advance) begin
        if (last_word) begin
          state         <= ST_DONE;
          scan_done     <= 1'b1;
          changed_count <= chg_cnt_next;
        end else begin
          idx           <= idx + IDX_W'(1);
          m_axi_araddr  <= word_addr(idx + IDX_W'(1));
          m_axi_arvalid <= 1'b1;
          state         <= ST_ADDR;
        end
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      for (int i = 0; i < STS_WORDS; i++) shadow[i] <= '0;
    end else if (word_changed) begin
      shadow[idx] <= m_axi_rdata;
    end
  end

endmodule

// File: tb/tb_axi_sts_alert_scanner.sv
// Self-checking bench: AXI-Lite status memory responder plus a word-level model
// of which words each scan must report.
module tb_axi_sts_alert_scanner;

  localparam int W    = 32;
  localparam int HOLD = 4;
  localparam int BASE = 'h100;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        enable = 1'b0;
  logic        alert = 1'b0;
  logic        scan_req = 1'b0;
  logic        busy, scan_done;
  logic [15:0] changed_count, err_count;
  logic [15:0] araddr;
  logic        arvalid, arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid, rready;
  logic [31:0] tdata;
  logic [15:0] tuser;
  logic        tvalid, tready;

  logic [31:0] mem     [W];
  bit          err_mask[W];
  logic [31:0] mshadow [W];
  int          merr;
  logic [47:0] got_q[$];
  logic [47:0] exp_q[$];
  bit          rand_mode = 1'b0;
  bit          tready_hold = 1'b0;
  int          total = 0;
  int          bad = 0;

  always #5 aclk = ~aclk;

  axi_sts_alert_scanner #(
    .STS_WORDS(W), .AXI_DATA_WIDTH(32), .AXI_ADDR_WIDTH(16),
    .BASE_ADDR(BASE), .HOLDOFF_CYCLES(HOLD)
  ) dut (
    .aclk(aclk), .aresetn(aresetn), .enable(enable), .alert(alert), .scan_req(scan_req),
    .busy(busy), .scan_done(scan_done), .changed_count(changed_count), .err_count(err_count),
    .m_axi_araddr(araddr), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
    .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid), .m_axi_rready(rready),
    .m_axis_tdata(tdata), .m_axis_tuser(tuser), .m_axis_tvalid(tvalid), .m_axis_tready(tready)
  );

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected events: every OKAY word whose value differs from what was last reported.
  task automatic predictScan();
    exp_q.delete();
    for (int i = 0; i < W; i++) begin
      if (err_mask[i]) begin
        if (merr < 'hFFFF) merr++;
      end else if (mem[i] !== mshadow[i]) begin
        exp_q.push_back({16'(i), mem[i]});
        mshadow[i] = mem[i];
      end
    end
  endtask

  task automatic checkEvents(input string tag);
    checkOutput({tag, "_nev"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (i < got_q.size()) checkOutput({tag, "_ev"}, got_q[i], exp_q[i]);
    checkOutput({tag, "_chg"}, changed_count, exp_q.size());
    checkOutput({tag, "_err"}, err_count, merr);
  endtask

  task automatic waitDone(input string tag, input int start, output int cyc);
    cyc = start;
    do begin
      @(negedge aclk);
      cyc++;
    end while (scan_done !== 1'b1 && cyc < 4000);
    checkOutput({tag, "_done"}, scan_done, 1);
  endtask

  task automatic waitIdle(input string tag);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 500) begin
      @(negedge aclk);
      n++;
    end
    if (n >= 500) checkOutput({tag, "_idle"}, busy, 0);
  endtask

  task automatic waitTvalid(input string tag);
    int n;
    n = 0;
    while (tvalid !== 1'b1 && n < 4000) begin
      @(negedge aclk);
      n++;
    end
    checkOutput({tag, "_tvalid"}, tvalid, 1);
  endtask

  task automatic applyStimulus(input bit use_alert, input string tag);
    int cyc;
    predictScan();
    got_q.delete();
    if (use_alert) begin
      waitIdle(tag);
      alert = 1'b1;
      @(negedge aclk);
      alert = 1'b0;
    end else begin
      scan_req = 1'b1;
      @(negedge aclk);
      scan_req = 1'b0;
    end
    waitDone(tag, 1, cyc);
    checkEvents(tag);
  endtask

  // Status register side: one read at a time, optional random stalls, event sink.
  initial begin : responder
    bit ar_hs, r_hs, rd_pend;
    int ar_idx, rd_idx, rdelay;
    arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00; tready = 1'b0;
    ar_hs = 0; r_hs = 0; rd_pend = 0; ar_idx = 0; rd_idx = 0; rdelay = 0;
    forever begin
      @(negedge aclk);
      #1;
      if (!aresetn) begin
        arready = 1'b0; rvalid = 1'b0; tready = 1'b0;
        ar_hs = 0; r_hs = 0; rd_pend = 0;
      end else begin
        if (r_hs) begin
          rvalid  = 1'b0;
          rd_pend = 0;
        end
        if (ar_hs) begin
          rd_pend = 1;
          rd_idx  = (ar_idx >= 0 && ar_idx < W) ? ar_idx : 0;
          rdelay  = rand_mode ? $urandom_range(0, 3) : 0;
        end
        arready = rand_mode ? ($urandom_range(0, 1) == 1) : 1'b1;
        ar_hs   = arvalid && arready;
        if (ar_hs) ar_idx = (int'(araddr) - BASE) >> 2;
        if (rd_pend && !rvalid) begin
          if (rdelay == 0) begin
            rvalid = 1'b1;
            rdata  = mem[rd_idx];
            rresp  = err_mask[rd_idx] ? 2'b10 : 2'b00;
          end else begin
            rdelay--;
          end
        end
        r_hs   = rvalid && rready;
        tready = tready_hold ? 1'b0 : (rand_mode ? ($urandom_range(0, 1) == 1) : 1'b1);
        if (tvalid && tready) got_q.push_back({tuser, tdata});
      end
    end
  end

  initial begin : watchdog
    #1000000;
    bad++;
    $display("[TB] FAIL watchdog got=running exp=finished");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    int cyc, low, pulses, nchg;
    for (int i = 0; i < W; i++) begin
      mem[i] = '0; err_mask[i] = 0; mshadow[i] = '0;
    end
    merr = 0;

    repeat (3) @(negedge aclk);
    checkOutput("rst_arvalid", arvalid, 0);
    checkOutput("rst_rready", rready, 0);
    checkOutput("rst_tvalid", tvalid, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_scan_done", scan_done, 0);
    checkOutput("rst_araddr", araddr, BASE);
    checkOutput("rst_tdata", tdata, 0);
    checkOutput("rst_tuser", tuser, 0);
    checkOutput("rst_changed", changed_count, 0);
    checkOutput("rst_err", err_count, 0);
    aresetn = 1'b1;
    enable  = 1'b1;
    @(negedge aclk);

    $display("[TB] first scan on alert, word1=5");
    mem[1] = 32'h5;
    predictScan();
    got_q.delete();
    alert = 1'b1;
    @(negedge aclk);
    alert = 1'b0;
    checkOutput("trig_arvalid", arvalid, 1);
    checkOutput("trig_araddr", araddr, BASE);
    waitDone("scan1", 1, cyc);
    checkOutput("scan1_latency", cyc, 2 * W + 2);
    checkEvents("scan1");

    $display("[TB] unchanged rescan via scan_req");
    applyStimulus(0, "rescan");

    $display("[TB] word31 change with tready stall");
    mem[31] = 32'hDEADBEEF;
    predictScan();
    got_q.delete();
    tready_hold = 1'b1;
    scan_req = 1'b1;
    @(negedge aclk);
    scan_req = 1'b0;
    waitTvalid("stall");
    for (int k = 0; k < 10; k++) begin
      @(negedge aclk);
      checkOutput("stall_tvalid", tvalid, 1);
      checkOutput("stall_tuser", tuser, 31);
      checkOutput("stall_tdata", tdata, 32'hDEADBEEF);
      checkOutput("stall_arvalid", arvalid, 0);
    end
    tready_hold = 1'b0;
    waitDone("stall", 0, cyc);
    checkEvents("stall");

    $display("[TB] error response on word3");
    mem[3] = 32'h77;
    err_mask[3] = 1;
    applyStimulus(0, "errscan");
    err_mask[3] = 0;
    applyStimulus(0, "errfix");

    $display("[TB] randomized scans with backpressure");
    rand_mode = 1'b1;
    for (int r = 0; r < 4; r++) begin
      nchg = $urandom_range(0, 5);
      for (int k = 0; k < nchg; k++) mem[$urandom_range(0, W - 1)] = $urandom;
      for (int k = 0; k < W; k++) err_mask[k] = ($urandom_range(0, 15) == 0);
      applyStimulus(r[0], "rand");
    end
    rand_mode = 1'b0;
    for (int k = 0; k < W; k++) err_mask[k] = 0;
    applyStimulus(0, "rand_settle");

    $display("[TB] alert held high");
    waitIdle("hold");
    alert = 1'b1;
    waitDone("hold_a", 0, cyc);
    cyc = 0;
    low = 0;
    do begin
      @(negedge aclk);
      cyc++;
      if (busy === 1'b0) low++;
    end while (arvalid !== 1'b1 && cyc < 100);
    checkOutput("hold_gap", cyc, HOLD + 2);
    checkOutput("hold_busy_low", low, 1);
    repeat (10) @(negedge aclk);
    scan_req = 1'b1;
    alert = 1'b0;
    @(negedge aclk);
    scan_req = 1'b0;
    waitDone("hold_b", 0, cyc);
    pulses = 0;
    repeat (300) begin
      @(negedge aclk);
      if (scan_done === 1'b1) pulses++;
    end
    checkOutput("extra_scans", pulses, 1);
    checkOutput("hold_end_busy", busy, 0);

    $display("[TB] reset during EMIT");
    mem[10] = 32'hABCD0123;
    tready_hold = 1'b1;
    got_q.delete();
    scan_req = 1'b1;
    @(negedge aclk);
    scan_req = 1'b0;
    waitTvalid("rst_emit");
    aresetn = 1'b0;
    @(negedge aclk);
    checkOutput("rst_emit_tvalid", tvalid, 0);
    checkOutput("rst_emit_busy", busy, 0);
    checkOutput("rst_emit_changed", changed_count, 0);
    checkOutput("rst_emit_err", err_count, 0);
    checkOutput("rst_emit_arvalid", arvalid, 0);
    aresetn = 1'b1;
    tready_hold = 1'b0;
    for (int k = 0; k < W; k++) mshadow[k] = '0;
    merr = 0;
    @(negedge aclk);
    applyStimulus(1, "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
